// File: rtl/axi_protocol_checker.sv
// AXI4 passive protocol checker: watches all five channels, raises sticky
// error bits, and tracks outstanding write/read bursts.

// Per-channel VALID/payload stability and VALID-without-READY timeout monitor.
module axi_chk_chan #(
   parameter int unsigned W         = 1,
   parameter int unsigned C_TIMEOUT = 0
) (
   input  logic         AXI_ACLK,
   input  logic         AXI_ARESET_N,
   input  logic         valid,
   input  logic         ready,
   input  logic [W-1:0] payload,
   output logic         stab_err_c,
   output logic         tmo_err_c
);
   logic         hold_q;
   logic [W-1:0] payload_q;

   // Remember whether the channel was stalled and what it was offering.
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
      if (!AXI_ARESET_N) begin
         hold_q    <= 1'b0;
         payload_q <= '0;
      end else begin
         hold_q    <= valid & ~ready;
         payload_q <= payload;
      end
   end

   // A stalled transfer must keep VALID and payload; unknown payload at a handshake also counts.
   always_comb begin
      stab_err_c = 1'b0;
      if (hold_q && (!valid || (payload != payload_q)))
         stab_err_c = 1'b1;
      if (valid && ready && ((^payload) === 1'bx))
         stab_err_c = 1'b1;
   end

   if (C_TIMEOUT > 0) begin : g_tmo
      localparam int unsigned TW = $clog2(C_TIMEOUT + 1);
      logic [TW-1:0] wait_q;

      // Count consecutive stalled cycles, saturating at the limit.
      always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
         if (!AXI_ARESET_N)
            wait_q <= '0;
         else if (!valid || ready)
            wait_q <= '0;
         else if (wait_q != TW'(C_TIMEOUT))
            wait_q <= wait_q + TW'(1);
      end

      assign tmo_err_c = valid && !ready && (wait_q == TW'(C_TIMEOUT - 1));
   end else begin : g_no_tmo
      assign tmo_err_c = 1'b0;
   end
endmodule

module axi_protocol_checker #(
   parameter int unsigned C_AXI_ID_WIDTH    = 10,
   parameter int unsigned C_AXI_ADDR_WIDTH  = 32,
   parameter int unsigned C_AXI_DATA_WIDTH  = 32,
   parameter int unsigned C_AXI_LEN_WIDTH   = 8,
   parameter int unsigned C_MAX_OUTSTANDING = 8,
   parameter int unsigned C_TIMEOUT         = 1024,
   localparam int unsigned C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH / 8,
   localparam int unsigned CW               = $clog2(C_MAX_OUTSTANDING) + 1
) (
   input  logic                          AXI_ACLK,
   input  logic                          AXI_ARESET_N,
   // write address
   input  logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
   input  logic [C_AXI_LEN_WIDTH-1:0]    AXI_AWLEN,
   input  logic [2:0]                    AXI_AWSIZE,
   input  logic [1:0]                    AXI_AWBURST,
   input  logic                          AXI_AWVALID,
   input  logic                          AXI_AWREADY,
   // write data
   input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
   input  logic [C_AXI_STRB_WIDTH-1:0]   AXI_WSTRB,
   input  logic                          AXI_WLAST,
   input  logic                          AXI_WVALID,
   input  logic                          AXI_WREADY,
   // write response
   input  logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
   input  logic [1:0]                    AXI_BRESP,
   input  logic                          AXI_BVALID,
   input  logic                          AXI_BREADY,
   // read address
   input  logic [C_AXI_ID_WIDTH-1:0]     AXI_ARID,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
   input  logic [C_AXI_LEN_WIDTH-1:0]    AXI_ARLEN,
   input  logic [2:0]                    AXI_ARSIZE,
   input  logic [1:0]                    AXI_ARBURST,
   input  logic                          AXI_ARVALID,
   input  logic                          AXI_ARREADY,
   // read data
   input  logic [C_AXI_ID_WIDTH-1:0]     AXI_RID,
   input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
   input  logic [1:0]                    AXI_RRESP,
   input  logic                          AXI_RLAST,
   input  logic                          AXI_RVALID,
   input  logic                          AXI_RREADY,
   // control / status
   input  logic                          chk_en,
   input  logic                          err_clr,
   output logic [11:0]                   err_vec,
   output logic                          err_pulse,
   output logic [3:0]                    first_err,
   output logic [CW-1:0]                 wr_outstanding,
   output logic [CW-1:0]                 rd_outstanding
);
   localparam int unsigned ERR_W = 12;
   localparam int unsigned PW    = $clog2(C_MAX_OUTSTANDING);
   localparam int unsigned BW    = C_AXI_LEN_WIDTH + 1;
   localparam int unsigned AW_PW = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH + C_AXI_LEN_WIDTH + 5;
   localparam int unsigned W_PW  = C_AXI_DATA_WIDTH + C_AXI_STRB_WIDTH + 1;
   localparam int unsigned B_PW  = C_AXI_ID_WIDTH + 2;
   localparam int unsigned R_PW  = C_AXI_ID_WIDTH + C_AXI_DATA_WIDTH + 3;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [4:0] stab_c, tmo_c;

   assign aw_hs = AXI_AWVALID & AXI_AWREADY;
   assign w_hs  = AXI_WVALID  & AXI_WREADY;
   assign b_hs  = AXI_BVALID  & AXI_BREADY;
   assign ar_hs = AXI_ARVALID & AXI_ARREADY;
   assign r_hs  = AXI_RVALID  & AXI_RREADY;

   axi_chk_chan #(.W(AW_PW), .C_TIMEOUT(C_TIMEOUT)) u_aw (
      .AXI_ACLK, .AXI_ARESET_N, .valid(AXI_AWVALID), .ready(AXI_AWREADY),
      .payload({AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST}),
      .stab_err_c(stab_c[0]), .tmo_err_c(tmo_c[0]));
   axi_chk_chan #(.W(W_PW), .C_TIMEOUT(C_TIMEOUT)) u_w (
      .AXI_ACLK, .AXI_ARESET_N, .valid(AXI_WVALID), .ready(AXI_WREADY),
      .payload({AXI_WDATA, AXI_WSTRB, AXI_WLAST}),
      .stab_err_c(stab_c[1]), .tmo_err_c(tmo_c[1]));
   axi_chk_chan #(.W(B_PW), .C_TIMEOUT(C_TIMEOUT)) u_b (
      .AXI_ACLK, .AXI_ARESET_N, .valid(AXI_BVALID), .ready(AXI_BREADY),
      .payload({AXI_BID, AXI_BRESP}),
      .stab_err_c(stab_c[2]), .tmo_err_c(tmo_c[2]));
   axi_chk_chan #(.W(AW_PW), .C_TIMEOUT(C_TIMEOUT)) u_ar (
      .AXI_ACLK, .AXI_ARESET_N, .valid(AXI_ARVALID), .ready(AXI_ARREADY),
      .payload({AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST}),
      .stab_err_c(stab_c[3]), .tmo_err_c(tmo_c[3]));
   axi_chk_chan #(.W(R_PW), .C_TIMEOUT(C_TIMEOUT)) u_r (
      .AXI_ACLK, .AXI_ARESET_N, .valid(AXI_RVALID), .ready(AXI_RREADY),
      .payload({AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST}),
      .stab_err_c(stab_c[4]), .tmo_err_c(tmo_c[4]));

   // Write-burst length queue and beat tracking state
   logic [C_AXI_LEN_WIDTH-1:0] fifo_q [C_MAX_OUTSTANDING];
   logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]              fifo_cnt_q, cmpl_q;
   logic [BW-1:0]              bcnt_q, bcnt_d;
   logic                       resync_q, resync_d;
   logic [C_AXI_LEN_WIDTH-1:0] head_len_c;
   logic aw_ovf_c, ar_ovf_c, push_c, pop_c, b_dec_c, r_dec_c;
   logic w_empty_c, w_early_c, w_miss_c, b_orphan_c, r_orphan_c;
   logic [ERR_W-1:0] err_new_c;
   logic [3:0]       low_idx_c;

   assign head_len_c = fifo_q[rd_ptr_q];
   assign aw_ovf_c   = aw_hs && (wr_outstanding == CW'(C_MAX_OUTSTANDING));
   assign ar_ovf_c   = ar_hs && (rd_outstanding == CW'(C_MAX_OUTSTANDING));
   assign push_c     = aw_hs && !aw_ovf_c && (fifo_cnt_q != CW'(C_MAX_OUTSTANDING));
   assign b_dec_c    = b_hs && (wr_outstanding != '0);
   assign r_dec_c    = r_hs && AXI_RLAST && (rd_outstanding != '0);
   assign b_orphan_c = b_hs && (cmpl_q == '0);
   assign r_orphan_c = r_hs && (rd_outstanding == '0);

   // Check each W beat against the head burst length; resync on WLAST.
   always_comb begin
      w_empty_c = 1'b0;
      w_early_c = 1'b0;
      w_miss_c  = 1'b0;
      pop_c     = 1'b0;
      bcnt_d    = bcnt_q;
      resync_d  = resync_q;
      if (w_hs) begin
         if (fifo_cnt_q == '0) begin
            w_empty_c = 1'b1;
         end else if (AXI_WLAST) begin
            pop_c    = 1'b1;
            bcnt_d   = '0;
            resync_d = 1'b0;
            if (!resync_q && (bcnt_q < BW'(head_len_c)))
               w_early_c = 1'b1;
         end else begin
            if (!resync_q && (bcnt_q == BW'(head_len_c))) begin
               w_miss_c = 1'b1;
               resync_d = 1'b1;
            end
            if (bcnt_q != '1)
               bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   // Burst length storage; entries are only read while the queue is non-empty.
   always_ff @(posedge AXI_ACLK) begin
      if (push_c)
         fifo_q[wr_ptr_q] <= AXI_AWLEN;
   end

   // Queue pointers, beat counter and outstanding/completed counters.
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
      if (!AXI_ARESET_N) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fifo_cnt_q     <= '0;
         cmpl_q         <= '0;
         bcnt_q         <= '0;
         resync_q       <= 1'b0;
         wr_outstanding <= '0;
         rd_outstanding <= '0;
      end else begin
         bcnt_q   <= bcnt_d;
         resync_q <= resync_d;
         if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_c, pop_c})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
         case ({pop_c && (cmpl_q != '1), b_hs && (cmpl_q != '0)})
            2'b10:   cmpl_q <= cmpl_q + CW'(1);
            2'b01:   cmpl_q <= cmpl_q - CW'(1);
            default: cmpl_q <= cmpl_q;
         endcase
         case ({aw_hs && !aw_ovf_c, b_dec_c})
            2'b10:   wr_outstanding <= wr_outstanding + CW'(1);
            2'b01:   wr_outstanding <= wr_outstanding - CW'(1);
            default: wr_outstanding <= wr_outstanding;
         endcase
         case ({ar_hs && !ar_ovf_c, r_dec_c})
            2'b10:   rd_outstanding <= rd_outstanding + CW'(1);
            2'b01:   rd_outstanding <= rd_outstanding - CW'(1);
            default: rd_outstanding <= rd_outstanding;
         endcase
      end
   end

   // Gather this cycle's raw errors and pick the lowest-numbered one.
   always_comb begin
      err_new_c = {|tmo_c, aw_ovf_c | ar_ovf_c, r_orphan_c, b_orphan_c,
                   w_empty_c, w_miss_c, w_early_c, stab_c} & {ERR_W{chk_en}};
      low_idx_c = '0;
      for (int i = ERR_W - 1; i >= 0; i--)
         if (err_new_c[i]) low_idx_c = 4'(i);
   end

   // Sticky error vector with first-error capture; clear keeps only new errors.
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
      if (!AXI_ARESET_N) begin
         err_vec   <= '0;
         err_pulse <= 1'b0;
         first_err <= '0;
      end else if (err_clr) begin
         err_vec   <= err_new_c;
         err_pulse <= |err_new_c;
         first_err <= low_idx_c;
      end else begin
         err_vec   <= err_vec | err_new_c;
         err_pulse <= |(err_new_c & ~err_vec);
         if ((err_vec == '0) && (err_new_c != '0))
            first_err <= low_idx_c;
      end
   end
endmodule
